// File: rtl/addsub_rr_scheduler.sv
// Round-robin scheduler sharing one DW-bit add/sub unit among NREQ requesters.
// Latency: result valid 2 cycles after the req_ready cycle; one op in flight, 3-cycle minimum spacing.
// Backpressure: result held in RESP until the granted port's rsp_ready; req_ready stays low while busy.
module addsub_rr_scheduler #(
    parameter int NREQ = 2,
    parameter int DW   = 4,
    parameter int GW   = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    input  logic [NREQ-1:0]    req_mode,
    output logic [NREQ-1:0]    rsp_valid,
    input  logic [NREQ-1:0]    rsp_ready,
    output logic [DW-1:0]      rsp_sum,
    output logic               rsp_cout,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic               alu_mode,
    input  logic [DW-1:0]      alu_sum,
    input  logic               alu_cout,
    output logic               busy,
    output logic [GW-1:0]      grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

    state_t              state_q, state_d;
    logic [GW-1:0]       last_grant_q, last_grant_d;
    logic [GW-1:0]       grant_id_q, grant_id_d;
    logic [DW-1:0]       alu_a_q, alu_a_d;
    logic [DW-1:0]       alu_b_q, alu_b_d;
    logic                alu_mode_q, alu_mode_d;
    logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]       rsp_sum_q, rsp_sum_d;
    logic                rsp_cout_q, rsp_cout_d;

    logic                pick_vld;
    logic [GW-1:0]       pick_idx;
    logic [NREQ-1:0]     pick_oh;
    logic [DW-1:0]       pick_a;
    logic [DW-1:0]       pick_b;
    logic                pick_mode;
    logic                rsp_hit;

    // Round-robin pick: ports above last_grant first, then wrap to ports at or below it.
    always_comb begin
        pick_vld  = 1'b0;
        pick_idx  = '0;
        pick_oh   = '0;
        pick_a    = '0;
        pick_b    = '0;
        pick_mode = 1'b0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pick_vld && req_valid[i] &&
                    ((pass == 0) ? (i > int'(last_grant_q)) : (i <= int'(last_grant_q)))) begin
                    pick_vld   = 1'b1;
                    pick_idx   = GW'(i);
                    pick_oh[i] = 1'b1;
                    pick_a     = req_a[DW*i +: DW];
                    pick_b     = req_b[DW*i +: DW];
                    pick_mode  = req_mode[i];
                end
            end
        end
    end

    // rsp_valid_q is one-hot on the granted port, so masking avoids a variable index.
    assign rsp_hit = |(rsp_ready & rsp_valid_q);

    // Next-state and datapath updates; everything holds unless the current state changes it.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_mode_d   = alu_mode_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        req_ready    = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    req_ready  = pick_oh;
                    alu_a_d    = pick_a;
                    alu_b_d    = pick_b;
                    alu_mode_d = pick_mode;
                    grant_id_d = pick_idx;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Unit has had a full cycle to settle on the registered operands.
                rsp_sum_d   = alu_sum;
                rsp_cout_d  = alu_cout;
                rsp_valid_d = ONE_HOT0 << grant_id_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_hit) begin
                    rsp_valid_d  = '0;
                    last_grant_d = grant_id_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GW'(NREQ - 1);
            grant_id_q   <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_mode_q   <= 1'b0;
            rsp_valid_q  <= '0;
            rsp_sum_q    <= '0;
            rsp_cout_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_mode_q   <= alu_mode_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_mode  = alu_mode_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign grant_id  = grant_id_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_addsub_rr_scheduler.sv
// Directed bench for addsub_rr_scheduler with a 2-port and a 4-port instance.
// Each instance drives a behavioural 4-bit add/sub unit from its alu_* outputs.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_addsub_rr_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // 2-port instance
    logic       rst2_n;
    logic [1:0] r2_valid, r2_ready, r2_mode, s2_valid, s2_ready;
    logic [7:0] r2_a, r2_b;
    logic [3:0] s2_sum, a2_a, a2_b, a2_sum;
    logic       s2_cout, a2_mode, a2_cout, busy2;
    logic [2:0] gid2;

    // 4-port instance
    logic        rst4_n;
    logic [3:0]  r4_valid, r4_ready, r4_mode, s4_valid, s4_ready;
    logic [15:0] r4_a, r4_b;
    logic [3:0]  s4_sum, a4_a, a4_b, a4_sum;
    logic        s4_cout, a4_mode, a4_cout, busy4;
    logic [1:0]  gid4;

    // Shared arithmetic units: subtract is A + ~B + 1, carry out means no borrow.
    assign {a2_cout, a2_sum} = a2_mode ? ({1'b0, a2_a} + {1'b0, ~a2_b} + 5'd1) : ({1'b0, a2_a} + {1'b0, a2_b});
    assign {a4_cout, a4_sum} = a4_mode ? ({1'b0, a4_a} + {1'b0, ~a4_b} + 5'd1) : ({1'b0, a4_a} + {1'b0, a4_b});

    addsub_rr_scheduler #(.NREQ(2), .DW(4), .GW(3)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .req_valid(r2_valid), .req_ready(r2_ready), .req_a(r2_a), .req_b(r2_b), .req_mode(r2_mode),
        .rsp_valid(s2_valid), .rsp_ready(s2_ready), .rsp_sum(s2_sum), .rsp_cout(s2_cout),
        .alu_a(a2_a), .alu_b(a2_b), .alu_mode(a2_mode), .alu_sum(a2_sum), .alu_cout(a2_cout),
        .busy(busy2), .grant_id(gid2)
    );

    addsub_rr_scheduler #(.NREQ(4), .DW(4), .GW(2)) dut4 (
        .clk(clk), .rst_n(rst4_n),
        .req_valid(r4_valid), .req_ready(r4_ready), .req_a(r4_a), .req_b(r4_b), .req_mode(r4_mode),
        .rsp_valid(s4_valid), .rsp_ready(s4_ready), .rsp_sum(s4_sum), .rsp_cout(s4_cout),
        .alu_a(a4_a), .alu_b(a4_b), .alu_mode(a4_mode), .alu_sum(a4_sum), .alu_cout(a4_cout),
        .busy(busy4), .grant_id(gid4)
    );

    task automatic do_reset2();
        r2_valid = '0;
        s2_ready = '0;
        rst2_n   = 1'b0;
        repeat (2) @(negedge clk);
        rst2_n   = 1'b1;
    endtask

    task automatic test_reset();
        rst2_n = 1'b0; rst4_n = 1'b0;
        #1;
        chk_cnt++; if (busy2 !== 1'b0) $display("FAIL reset_busy2 got %b exp 0", busy2); else pass_cnt++;
        chk_cnt++; if (r2_ready !== 2'b00) $display("FAIL reset_req_ready2 got %b exp 00", r2_ready); else pass_cnt++;
        chk_cnt++; if (s2_valid !== 2'b00) $display("FAIL reset_rsp_valid2 got %b exp 00", s2_valid); else pass_cnt++;
        chk_cnt++; if ({a2_a, a2_b, a2_mode} !== 9'd0) $display("FAIL reset_alu2 got %b exp 0", {a2_a, a2_b, a2_mode}); else pass_cnt++;
        chk_cnt++; if ({s2_sum, s2_cout} !== 5'd0) $display("FAIL reset_rsp2 got %b exp 0", {s2_sum, s2_cout}); else pass_cnt++;
        chk_cnt++; if (gid2 !== 3'd0) $display("FAIL reset_grant_id2 got %0d exp 0", gid2); else pass_cnt++;
        chk_cnt++; if (busy4 !== 1'b0) $display("FAIL reset_busy4 got %b exp 0", busy4); else pass_cnt++;
        chk_cnt++; if (gid4 !== 2'd0) $display("FAIL reset_grant_id4 got %0d exp 0", gid4); else pass_cnt++;
        repeat (2) @(negedge clk);
        rst2_n = 1'b1; rst4_n = 1'b1;
    endtask

    task automatic test_single_add();
        @(negedge clk);
        r2_valid = 2'b01; r2_a[3:0] = 4'b0001; r2_b[3:0] = 4'b0010; r2_mode[0] = 1'b0;
        #1;
        chk_cnt++; if (r2_ready !== 2'b01) $display("FAIL single_req_ready got %b exp 01", r2_ready); else pass_cnt++;
        @(negedge clk);
        r2_valid = 2'b00;
        chk_cnt++; if (r2_ready !== 2'b00) $display("FAIL single_ready_issue got %b exp 00", r2_ready); else pass_cnt++;
        chk_cnt++; if (busy2 !== 1'b1) $display("FAIL single_busy got %b exp 1", busy2); else pass_cnt++;
        chk_cnt++; if (a2_a !== 4'b0001) $display("FAIL single_alu_a got %b exp 0001", a2_a); else pass_cnt++;
        chk_cnt++; if (s2_valid !== 2'b00) $display("FAIL single_early_valid got %b exp 00", s2_valid); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (s2_valid !== 2'b01) $display("FAIL single_rsp_valid got %b exp 01", s2_valid); else pass_cnt++;
        chk_cnt++; if (s2_sum !== 4'b0011) $display("FAIL single_sum got %b exp 0011", s2_sum); else pass_cnt++;
        chk_cnt++; if (s2_cout !== 1'b0) $display("FAIL single_cout got %b exp 0", s2_cout); else pass_cnt++;
        s2_ready = 2'b01;
        @(negedge clk);
        s2_ready = 2'b00;
        chk_cnt++; if (s2_valid !== 2'b00) $display("FAIL single_valid_clear got %b exp 00", s2_valid); else pass_cnt++;
        chk_cnt++; if (busy2 !== 1'b0) $display("FAIL single_idle got %b exp 0", busy2); else pass_cnt++;
    endtask

    task automatic test_arith();
        logic [3:0] ta [5] = '{4'b1010, 4'b1111, 4'b1001, 4'b0100, 4'b0000};
        logic [3:0] tb [5] = '{4'b0101, 4'b0001, 4'b0011, 4'b1000, 4'b0000};
        logic       tm [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [3:0] ts [5] = '{4'b1111, 4'b0000, 4'b0110, 4'b1100, 4'b0000};
        logic       tc [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [1:0] oh;
        for (int k = 0; k < 5; k++) begin
            int p;
            p  = k % 2;
            oh = 2'b01 << p;
            @(negedge clk);
            r2_a[4*p +: 4] = ta[k]; r2_b[4*p +: 4] = tb[k]; r2_mode[p] = tm[k];
            r2_valid = oh;
            #1;
            chk_cnt++; if (r2_ready !== oh) $display("FAIL arith%0d_req_ready got %b exp %b", k, r2_ready, oh); else pass_cnt++;
            @(negedge clk);
            r2_valid = 2'b00;
            @(negedge clk);
            chk_cnt++; if (s2_valid !== oh) $display("FAIL arith%0d_rsp_valid got %b exp %b", k, s2_valid, oh); else pass_cnt++;
            chk_cnt++; if (s2_sum !== ts[k]) $display("FAIL arith%0d_sum got %b exp %b", k, s2_sum, ts[k]); else pass_cnt++;
            chk_cnt++; if (s2_cout !== tc[k]) $display("FAIL arith%0d_cout got %b exp %b", k, s2_cout, tc[k]); else pass_cnt++;
            s2_ready = oh;
            @(negedge clk);
            s2_ready = 2'b00;
        end
    endtask

    task automatic test_contention();
        logic [1:0] oh;
        logic [3:0] es;
        logic       ec;
        do_reset2();
        // port 0: 0011+0100 = 0111 c0 ; port 1: 1100-0001 = 1011 c1
        r2_a = {4'b1100, 4'b0011}; r2_b = {4'b0001, 4'b0100}; r2_mode = 2'b10;
        r2_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            oh = 2'b01 << (n % 2);
            es = (n % 2 == 0) ? 4'b0111 : 4'b1011;
            ec = (n % 2 == 0) ? 1'b0 : 1'b1;
            #1;
            chk_cnt++; if (r2_ready !== oh) $display("FAIL cont%0d_req_ready got %b exp %b", n, r2_ready, oh); else pass_cnt++;
            @(negedge clk);
            chk_cnt++; if (gid2 !== 3'(n % 2)) $display("FAIL cont%0d_grant_id got %0d exp %0d", n, gid2, n % 2); else pass_cnt++;
            @(negedge clk);
            chk_cnt++; if (s2_valid !== oh) $display("FAIL cont%0d_rsp_valid got %b exp %b", n, s2_valid, oh); else pass_cnt++;
            chk_cnt++; if (s2_sum !== es) $display("FAIL cont%0d_sum got %b exp %b", n, s2_sum, es); else pass_cnt++;
            chk_cnt++; if (s2_cout !== ec) $display("FAIL cont%0d_cout got %b exp %b", n, s2_cout, ec); else pass_cnt++;
            s2_ready = oh;
            @(negedge clk);
            s2_ready = 2'b00;
        end
        r2_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        // port 0: 0110+0011 = 1001 c0 ; port 1: 0111-0010 = 0101 c1
        r2_a = {4'b0111, 4'b0110}; r2_b = {4'b0010, 4'b0011}; r2_mode = 2'b10;
        r2_valid = 2'b11;
        #1;
        chk_cnt++; if (r2_ready !== 2'b01) $display("FAIL bp_first_grant got %b exp 01", r2_ready); else pass_cnt++;
        @(negedge clk);
        r2_valid = 2'b10;
        @(negedge clk);
        chk_cnt++; if (s2_valid !== 2'b01) $display("FAIL bp_rsp_valid got %b exp 01", s2_valid); else pass_cnt++;
        // ready on the non-granted port must be ignored
        s2_ready = 2'b10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_cnt++; if (s2_valid !== 2'b01) $display("FAIL bp%0d_rsp_valid got %b exp 01", c, s2_valid); else pass_cnt++;
            chk_cnt++; if (s2_sum !== 4'b1001) $display("FAIL bp%0d_sum got %b exp 1001", c, s2_sum); else pass_cnt++;
            chk_cnt++; if (s2_cout !== 1'b0) $display("FAIL bp%0d_cout got %b exp 0", c, s2_cout); else pass_cnt++;
            chk_cnt++; if (r2_ready !== 2'b00) $display("FAIL bp%0d_req_ready got %b exp 00", c, r2_ready); else pass_cnt++;
        end
        s2_ready = 2'b01;
        @(negedge clk);
        s2_ready = 2'b00;
        chk_cnt++; if (r2_ready !== 2'b10) $display("FAIL bp_port1_grant got %b exp 10", r2_ready); else pass_cnt++;
        @(negedge clk);
        r2_valid = 2'b00;
        chk_cnt++; if (gid2 !== 3'd1) $display("FAIL bp_grant_id got %0d exp 1", gid2); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (s2_valid !== 2'b10) $display("FAIL bp_port1_valid got %b exp 10", s2_valid); else pass_cnt++;
        chk_cnt++; if ({s2_sum, s2_cout} !== 5'b01011) $display("FAIL bp_port1_result got %b exp 01011", {s2_sum, s2_cout}); else pass_cnt++;
        s2_ready = 2'b10;
        @(negedge clk);
        s2_ready = 2'b00;
        chk_cnt++; if (s2_valid !== 2'b00) $display("FAIL bp_done got %b exp 00", s2_valid); else pass_cnt++;
    endtask

    task automatic test_reset_midop();
        // complete one port 0 op so that, without reset, port 1 would be next in line
        @(negedge clk);
        r2_a[3:0] = 4'b0001; r2_b[3:0] = 4'b0001; r2_mode[0] = 1'b0; r2_valid = 2'b01;
        @(negedge clk);
        r2_valid = 2'b00;
        @(negedge clk);
        s2_ready = 2'b01;
        @(negedge clk);
        s2_ready = 2'b00;
        r2_a[7:4] = 4'b1111; r2_b[7:4] = 4'b0001; r2_mode[1] = 1'b0; r2_valid = 2'b10;
        @(negedge clk);
        r2_valid = 2'b00;
        chk_cnt++; if (a2_a !== 4'b1111) $display("FAIL mid_issue_alu_a got %b exp 1111", a2_a); else pass_cnt++;
        #2 rst2_n = 1'b0;
        #1;
        chk_cnt++; if (busy2 !== 1'b0) $display("FAIL mid_busy got %b exp 0", busy2); else pass_cnt++;
        chk_cnt++; if ({a2_a, a2_b, a2_mode} !== 9'd0) $display("FAIL mid_alu got %b exp 0", {a2_a, a2_b, a2_mode}); else pass_cnt++;
        chk_cnt++; if (gid2 !== 3'd0) $display("FAIL mid_grant_id got %0d exp 0", gid2); else pass_cnt++;
        @(negedge clk);
        rst2_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_cnt++; if ({s2_valid, busy2} !== 3'b000) $display("FAIL mid%0d_no_rsp got %b exp 000", c, {s2_valid, busy2}); else pass_cnt++;
        end
        r2_a[3:0] = 4'b0010; r2_b[3:0] = 4'b0010; r2_mode = 2'b00; r2_valid = 2'b11;
        #1;
        chk_cnt++; if (r2_ready !== 2'b01) $display("FAIL mid_first_grant got %b exp 01", r2_ready); else pass_cnt++;
        @(negedge clk);
        r2_valid = 2'b00;
        @(negedge clk);
        chk_cnt++; if ({s2_valid, s2_sum, s2_cout} !== 7'b0101000) $display("FAIL mid_result got %b exp 0101000", {s2_valid, s2_sum, s2_cout}); else pass_cnt++;
        s2_ready = 2'b01;
        @(negedge clk);
        s2_ready = 2'b00;
    endtask

    task automatic test_sparse_wrap();
        @(negedge clk);
        // port 3: 0101-0011 = 0010 c1
        r4_a[15:12] = 4'b0101; r4_b[15:12] = 4'b0011; r4_mode[3] = 1'b1; r4_valid = 4'b1000;
        #1;
        chk_cnt++; if (r4_ready !== 4'b1000) $display("FAIL wrap_p3_ready got %b exp 1000", r4_ready); else pass_cnt++;
        @(negedge clk);
        r4_valid = 4'b0000;
        chk_cnt++; if (gid4 !== 2'd3) $display("FAIL wrap_p3_grant_id got %0d exp 3", gid4); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (s4_valid !== 4'b1000) $display("FAIL wrap_p3_valid got %b exp 1000", s4_valid); else pass_cnt++;
        chk_cnt++; if ({s4_sum, s4_cout} !== 5'b00101) $display("FAIL wrap_p3_result got %b exp 00101", {s4_sum, s4_cout}); else pass_cnt++;
        s4_ready = 4'b1000;
        @(negedge clk);
        s4_ready = 4'b0000;
        @(negedge clk);
        chk_cnt++; if (busy4 !== 1'b0) $display("FAIL wrap_gap_busy got %b exp 0", busy4); else pass_cnt++;
        // port 0: 1000+1000 = 0000 c1
        r4_a[3:0] = 4'b1000; r4_b[3:0] = 4'b1000; r4_mode[0] = 1'b0; r4_valid = 4'b0001;
        #1;
        chk_cnt++; if (r4_ready !== 4'b0001) $display("FAIL wrap_p0_ready got %b exp 0001", r4_ready); else pass_cnt++;
        @(negedge clk);
        r4_valid = 4'b0000;
        chk_cnt++; if (gid4 !== 2'd0) $display("FAIL wrap_p0_grant_id got %0d exp 0", gid4); else pass_cnt++;
        @(negedge clk);
        chk_cnt++; if (s4_valid !== 4'b0001) $display("FAIL wrap_p0_valid got %b exp 0001", s4_valid); else pass_cnt++;
        chk_cnt++; if ({s4_sum, s4_cout} !== 5'b00001) $display("FAIL wrap_p0_result got %b exp 00001", {s4_sum, s4_cout}); else pass_cnt++;
        s4_ready = 4'b0001;
        @(negedge clk);
        s4_ready = 4'b0000;
        chk_cnt++; if (busy4 !== 1'b0) $display("FAIL wrap_end_busy got %b exp 0", busy4); else pass_cnt++;
        // last grant was 0: ports 0 and 2 pending -> port 2 comes next
        r4_valid = 4'b0101;
        #1;
        chk_cnt++; if (r4_ready !== 4'b0100) $display("FAIL wrap_rr_order got %b exp 0100", r4_ready); else pass_cnt++;
        r4_valid = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst2_n = 1'b0; rst4_n = 1'b0;
        r2_valid = '0; r2_a = '0; r2_b = '0; r2_mode = '0; s2_ready = '0;
        r4_valid = '0; r4_a = '0; r4_b = '0; r4_mode = '0; s4_ready = '0;
        test_reset();
        test_single_add();
        test_arith();
        test_contention();
        test_backpressure();
        test_reset_midop();
        test_sparse_wrap();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/addsub_rr_scheduler.md
Name: addsub_rr_scheduler

Overview:
- Shares one combinational 4-bit adder/subtractor unit (`A`, `B`, `mode` in; `Sum`, `CarryOut` out) between NREQ requesters.
- Arbitration is round-robin. The block registers the chosen operands onto the unit, captures the result, and returns it to the granted requester over a valid/ready response channel.
- It sits between requester logic and the single arithmetic instance. One operation is in flight at a time.

Parameters:
- NREQ, 2, number of requesters (legal range 2..8).
- DW, 4, operand width; must match the shared unit.
- GW, 3, width of the grant index; must satisfy 2^GW >= NREQ.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  requester i has an operation pending
- req_ready  out  NREQ  one-hot accept pulse to requester i
- req_a  in  NREQ*DW  operand A, slice [DW*i +: DW]
- req_b  in  NREQ*DW  operand B, slice [DW*i +: DW]
- req_mode  in  NREQ  0 = add, 1 = subtract
- rsp_valid  out  NREQ  one-hot; result available for requester i
- rsp_ready  in  NREQ  requester i takes the result
- rsp_sum  out  DW  result, shared by all requesters
- rsp_cout  out  1  carry/no-borrow flag, shared by all requesters
- alu_a  out  DW  registered, drives unit A
- alu_b  out  DW  registered, drives unit B
- alu_mode  out  1  registered, drives unit mode
- alu_sum  in  DW  unit Sum
- alu_cout  in  1  unit CarryOut
- busy  out  1  high in any state other than IDLE
- grant_id  out  GW  index of the current or last granted requester

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - req_ready, rsp_valid, alu_a, alu_b, alu_mode, rsp_sum, rsp_cout, busy all 0.
  - last_grant=NREQ-1, so requester 0 has first priority.
  - grant_id=0.
- State machine: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - If any req_valid bit is set, select g = first set bit scanning last_grant+1, last_grant+2, ... with wrap modulo NREQ.
  - Same cycle (combinational from req_valid and last_grant): req_ready[g]=1, all other req_ready bits 0.
  - Clock edge: alu_a<=req_a[g], alu_b<=req_b[g], alu_mode<=req_mode[g], grant_id<=g, state<=ISSUE.
  - If no request: remain in IDLE; req_ready=0.
- ISSUE (1 cycle):
  - The unit settles on the registered operands.
  - Edge: rsp_sum<=alu_sum, rsp_cout<=alu_cout, rsp_valid[grant_id]<=1, state<=RESP.
- RESP:
  - rsp_valid[grant_id] stays high. rsp_sum, rsp_cout and alu_* are held stable.
  - When rsp_ready[grant_id]=1: edge clears rsp_valid, sets last_grant<=grant_id, state<=IDLE.
  - rsp_ready on non-granted bits is ignored.
- req_ready is 0 outside IDLE. New requests wait; they are never dropped and never partially accepted.
- Latency: accept edge to rsp_valid high is 2 cycles. Minimum issue interval per operation is 3 cycles.
- Arithmetic is performed entirely by the shared unit, and results pass through unmodified:
  - Add: carry out.
  - Subtract: two's complement, so cout=1 means no borrow.
- Simultaneous requests: exactly one grant per IDLE cycle. Round-robin guarantees a continuously requesting port waits at most NREQ-1 other operations.
- A requester deasserting req_valid before it is granted is legal; it is simply not selected.
- Requester i must hold req_a[i], req_b[i] and req_mode[i] stable while req_valid[i]=1 and req_ready[i]=0.
- Reset mid-operation (ISSUE or RESP): the in-flight result is discarded, no rsp_valid is produced, and all state returns to reset values.
- Only `rsp_valid[grant_id]` may ever be set, so rsp_valid is always one-hot or zero. req_ready is always one-hot or zero.

Test Plan:
- Single add, port 0: A=0001, B=0010, mode=0 -> req_ready[0] pulse, 2 cycles later rsp_valid[0], rsp_sum=0011, rsp_cout=0.
- Carry and subtract:
  - 1010+0101 -> 1111, cout 0.
  - 1111+0001 -> 0000, cout 1.
  - 1001-0011 (mode=1) -> 0110, cout 1.
  - 0100-1000 -> 1100, cout 0.
  - 0000-0000 -> 0000, cout 1.
- Contention, NREQ=2: both ports hold req_valid continuously. Grants go 0,1,0,1 and each port receives its own correct result on its own rsp_valid bit.
- Backpressure: hold rsp_ready[0]=0 for 5 cycles. rsp_valid[0], rsp_sum and rsp_cout stay stable, req_ready stays 0 despite a pending port 1, and port 1 is granted in the cycle after the handshake completes.
- Reset mid-op: assert rst_n=0 during ISSUE. Outputs go to 0 immediately (asynchronous), no response is issued, and after release port 0 is granted first.
- Sparse traffic with wrap: NREQ=4, only port 3 then port 0 request -> grants 3 then 0, grant_id matches, and busy is low between operations.
